// File: rtl/adr_range_search.sv
// Scans an inclusive address range of a 1-cycle-latency synchronous RAM and
// compares each returned word against a key. It pulses hit per match and done at the end.
module adr_range_search #(
    parameter int A = 8,
    parameter int D = 8,
    parameter int R = 256
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [A-1:0] adr_lo_i,
    input  logic [A-1:0] adr_hi_i,
    input  logic [D-1:0] key_i,
    input  logic         first_only_i,
    output logic [A-1:0] mem_addr_o,
    output logic         mem_rd_o,
    input  logic [D-1:0] mem_rdata_i,
    output logic         busy_o,
    output logic         hit_o,
    output logic [A-1:0] hit_addr_o,
    output logic [A:0]   hit_count_o,
    output logic         done_o
);

    localparam logic [A:0] HIT_MAX = (A+1)'(R);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state_q;
    logic [A-1:0] cur_q;
    logic [A-1:0] hi_q;
    logic [D-1:0] key_q;
    logic         first_only_q;
    logic [A-1:0] mem_addr_q;
    logic         mem_rd_q;
    logic         busy_q;
    logic         done_q;
    logic         cmp_vld_q;
    logic [A-1:0] cmp_addr_q;
    logic         hit_q;
    logic [A-1:0] hit_addr_q;
    logic [A:0]   hit_count_q;

    logic [A-1:0] lo_s;
    logic [A-1:0] hi_s;
    logic         accept_s;
    logic         match_s;
    logic         stop_s;

    // Order the incoming address pair so the scan always counts upward.
    always_comb begin
        lo_s = adr_lo_i;
        hi_s = adr_hi_i;
        if (adr_lo_i <= adr_hi_i) begin
            lo_s = adr_lo_i;
            hi_s = adr_hi_i;
        end else begin
            lo_s = adr_hi_i;
            hi_s = adr_lo_i;
        end
    end

    // Start acceptance and compare-stage decode.
    always_comb begin
        accept_s = start_i && (state_q == S_IDLE);
        match_s  = cmp_vld_q && (mem_rdata_i == key_q);
        stop_s   = match_s && first_only_q;
    end

    // Search sequencer with registered memory-port and status outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cur_q        <= {A{1'b0}};
            hi_q         <= {A{1'b0}};
            key_q        <= {D{1'b0}};
            first_only_q <= 1'b0;
            mem_addr_q   <= {A{1'b0}};
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        hi_q         <= hi_s;
                        key_q        <= key_i;
                        first_only_q <= first_only_i;
                        cur_q        <= lo_s;
                        mem_addr_q   <= lo_s;
                        mem_rd_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_SCAN;
                    end else begin
                        mem_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // Equality end test: hi = R-1 stops there instead of wrapping to 0.
                    if (stop_s) begin
                        mem_rd_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (cur_q == hi_q) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= S_DRAIN;
                    end else begin
                        cur_q      <= cur_q + 1'b1;
                        mem_addr_q <= cur_q + 1'b1;
                        mem_rd_q   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    mem_rd_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    mem_rd_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    mem_rd_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    // Compare pipeline: issue cycle -> compare cycle -> registered hit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= {A{1'b0}};
            hit_q       <= 1'b0;
            hit_addr_q  <= {A{1'b0}};
            hit_count_q <= {(A+1){1'b0}};
        end else begin
            // A first-only stop discards the read issued alongside the matching compare.
            cmp_vld_q  <= mem_rd_q && !stop_s;
            cmp_addr_q <= mem_addr_q;
            hit_q      <= match_s;
            if (match_s) begin
                hit_addr_q <= cmp_addr_q;
            end else begin
                hit_addr_q <= hit_addr_q;
            end
            if (accept_s) begin
                hit_count_q <= {(A+1){1'b0}};
            end else if (match_s && (hit_count_q != HIT_MAX)) begin
                hit_count_q <= hit_count_q + 1'b1;
            end else begin
                hit_count_q <= hit_count_q;
            end
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign hit_o       = hit_q;
    assign hit_addr_o  = hit_addr_q;
    assign hit_count_o = hit_count_q;

endmodule
